// File: rtl/rc_chk_pkg.sv
// Shared constants and fixed-point helpers for the RC step checker.
// Real values are signed fixed point; helpers widen before any arithmetic.
package rc_chk_pkg;

   localparam int CNT_W = 16;
   localparam int FX_W  = 32;

   // Stimulus FSM encoding
   localparam logic [1:0] LOW  = 2'd0;
   localparam logic [1:0] HIGH = 2'd1;
   localparam logic [1:0] HALT = 2'd2;

   function automatic int to_fx(input real x, input int frac);
      return $rtoi(x * (2.0 ** frac) + ((x < 0.0) ? -0.5 : 0.5));
   endfunction

   // One extra bit on the difference keeps |a - b| from wrapping
   function automatic logic in_band(input logic signed [FX_W-1:0] a,
                                    input logic signed [FX_W-1:0] b,
                                    input logic signed [FX_W-1:0] tol);
      logic signed [FX_W:0] ea;
      logic signed [FX_W:0] eb;
      logic signed [FX_W:0] et;
      logic signed [FX_W:0] diff;
      ea = {a[FX_W-1], a};
      eb = {b[FX_W-1], b};
      et = {tol[FX_W-1], tol};
      diff = ea - eb;
      if (diff < 0) diff = -diff;
      return diff <= et;
   endfunction

endpackage

// File: rtl/rc_model.sv
// First-order RC low-pass behavioural model: each cycle v_out moves 1/2^SHIFT
// of the way towards v_in. Held at zero while in reset.
module rc_model #(
   parameter int REAL_W = 18,
   parameter int SHIFT  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [REAL_W-1:0] v_in,
   output logic signed [REAL_W-1:0] v_out
);

   logic signed [REAL_W:0] diff;
   logic signed [REAL_W:0] step;
   logic signed [REAL_W:0] next;

   always_comb begin
      diff = {v_in[REAL_W-1], v_in} - {v_out[REAL_W-1], v_out};
      step = diff >>> SHIFT;
      next = {v_out[REAL_W-1], v_out} + step;
   end

   always_ff @(posedge clk) begin
      if (rst) v_out <= '0;
      else     v_out <= next[REAL_W-1:0];
   end

endmodule

// File: rtl/rc_settle_monitor.sv
// Per-phase settle tracking plus the always-on bound check. The *_hit outputs
// are the unregistered set conditions so the FSM can halt on the same edge.
module rc_settle_monitor
   import rc_chk_pkg::*;
#(
   parameter int REAL_W     = 18,
   parameter int TOL_I      = 205,
   parameter int VMIN_I     = -2048,
   parameter int VMAX_I     = 8192,
   parameter int SETTLE_MAX = 40
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run,
   input  logic                     wrap,
   input  logic signed [REAL_W-1:0] v_out,
   input  logic signed [REAL_W-1:0] target,
   output logic                     settled,
   output logic [CNT_W-1:0]         settle_time,
   output logic                     err_bound,
   output logic                     err_settle,
   output logic                     bound_hit,
   output logic                     settle_hit
);

   localparam logic signed [REAL_W-1:0] VMIN_FX = VMIN_I[REAL_W-1:0];
   localparam logic signed [REAL_W-1:0] VMAX_FX = VMAX_I[REAL_W-1:0];
   localparam logic [CNT_W-1:0]         SMAX    = SETTLE_MAX[CNT_W-1:0];

   logic [CNT_W-1:0]         settle_cnt;
   logic signed [FX_W-1:0]   vo_w;
   logic signed [FX_W-1:0]   tg_w;
   logic                     band;

   always_comb begin
      vo_w       = {{(FX_W-REAL_W){v_out[REAL_W-1]}}, v_out};
      tg_w       = {{(FX_W-REAL_W){target[REAL_W-1]}}, target};
      band       = in_band(vo_w, tg_w, TOL_I);
      bound_hit  = (v_out >= VMAX_FX) || (v_out <= VMIN_FX);
      settle_hit = run && !settled && !band && (settle_cnt == SMAX);
   end

   // A wrap restarts the phase even if the band is entered on that same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         settled     <= 1'b0;
         settle_time <= '0;
         settle_cnt  <= '0;
         err_bound   <= 1'b0;
         err_settle  <= 1'b0;
      end else begin
         err_bound  <= err_bound | bound_hit;
         err_settle <= err_settle | settle_hit;
         if (wrap) begin
            settled    <= 1'b0;
            settle_cnt <= '0;
         end else if (run && !settled) begin
            if (band) begin
               settled     <= 1'b1;
               settle_time <= settle_cnt;
            end else if (settle_cnt != '1) begin
               settle_cnt <= settle_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/rc_step_checker.sv
// Closed-loop harness: drives rc_model with a square-wave step sequence and
// flags bound violations and slow settling, optionally freezing on error.
module rc_step_checker
   import rc_chk_pkg::*;
#(
   parameter int  REAL_W      = 18,
   parameter int  REAL_FRAC   = 12,
   parameter real V_LO        = 0.0,
   parameter real V_HI        = 1.0,
   parameter real V_MIN       = -0.5,
   parameter real V_MAX       = 2.0,
   parameter real TOL         = 0.05,
   parameter int  HALF_PERIOD = 64,
   parameter int  SETTLE_MAX  = 40,
   parameter bit  STOP_ON_ERR = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   output logic signed [REAL_W-1:0] v_in,
   output logic signed [REAL_W-1:0] v_out,
   output logic                     phase_hi,
   output logic                     settled,
   output logic [15:0]              settle_time,
   output logic [15:0]              step_count,
   output logic                     err_bound,
   output logic                     err_settle,
   output logic                     halted
);

   localparam int V_LO_I = to_fx(V_LO, REAL_FRAC);
   localparam int V_HI_I = to_fx(V_HI, REAL_FRAC);
   localparam int LAST_I = HALF_PERIOD - 1;
   localparam logic signed [REAL_W-1:0] V_LO_FX = V_LO_I[REAL_W-1:0];
   localparam logic signed [REAL_W-1:0] V_HI_FX = V_HI_I[REAL_W-1:0];
   localparam logic [CNT_W-1:0]         LAST    = LAST_I[CNT_W-1:0];

   logic [1:0]               state;
   logic [CNT_W-1:0]         phase_cnt;
   logic                     running;
   logic                     halt_now;
   logic                     wrap;
   logic                     bound_hit;
   logic                     settle_hit;
   logic signed [REAL_W-1:0] target;

   // Halting takes priority over a wrap on the same edge
   always_comb begin
      running  = en && (state != HALT);
      halt_now = STOP_ON_ERR && (state != HALT) && (bound_hit || settle_hit);
      wrap     = running && !halt_now && (phase_cnt == LAST);
      target   = phase_hi ? V_HI_FX : V_LO_FX;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LOW;
         phase_cnt  <= '0;
         step_count <= '0;
         v_in       <= V_LO_FX;
         phase_hi   <= 1'b0;
         halted     <= 1'b0;
      end else if (halt_now) begin
         state  <= HALT;
         halted <= 1'b1;
      end else if (running) begin
         if (wrap) begin
            phase_cnt <= '0;
            if (step_count != '1) step_count <= step_count + CNT_W'(1);
            if (state == HIGH) begin
               state    <= LOW;
               phase_hi <= 1'b0;
               v_in     <= V_LO_FX;
            end else begin
               state    <= HIGH;
               phase_hi <= 1'b1;
               v_in     <= V_HI_FX;
            end
         end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
         end
      end
   end

   rc_model #(
      .REAL_W (REAL_W),
      .SHIFT  (3)
   ) u_model (
      .clk   (clk),
      .rst   (rst),
      .v_in  (v_in),
      .v_out (v_out)
   );

   rc_settle_monitor #(
      .REAL_W     (REAL_W),
      .TOL_I      (to_fx(TOL, REAL_FRAC)),
      .VMIN_I     (to_fx(V_MIN, REAL_FRAC)),
      .VMAX_I     (to_fx(V_MAX, REAL_FRAC)),
      .SETTLE_MAX (SETTLE_MAX)
   ) u_mon (
      .clk         (clk),
      .rst         (rst),
      .run         (running),
      .wrap        (wrap),
      .v_out       (v_out),
      .target      (target),
      .settled     (settled),
      .settle_time (settle_time),
      .err_bound   (err_bound),
      .err_settle  (err_settle),
      .bound_hit   (bound_hit),
      .settle_hit  (settle_hit)
   );

`ifdef FORMAL
   always_comb begin
      if (!rst) begin
         assert (!err_bound);
         assert (!err_settle);
      end
   end
`endif

endmodule

// File: doc/rc_step_checker.md
# rc_step_checker

Self-checking closed-loop harness for the RC behavioural model, generalised from a fixed constant stimulus plus a single bound property. It drives the `rc_model` input with a programmable square-wave step sequence and watches `v_out` each cycle. Per step it checks that `v_out` stays within a bound window and settles to the step target within a cycle budget. Sticky error flags and a formal assertion report failures. It sits at the top of the RC formal/simulation flow, in place of a fixed-stimulus top.

## Interface

Fixed-point format for all real values: signed, `REAL_W` bits, `REAL_FRAC` fractional bits. Real ports use the codebase real-number port macros with this format.

Parameters:
- `REAL_W`, 18: real signal width.
- `REAL_FRAC`, 12: fractional bits.
- `V_LO`, 0.0: low step level.
- `V_HI`, 1.0: high step level.
- `V_MIN`, -0.5: lower bound. A sample at or below it is an error.
- `V_MAX`, 2.0: upper bound. A sample at or above it is an error.
- `TOL`, 0.05: settle band half-width, inclusive.
- `HALF_PERIOD`, 64: cycles per step phase. Must be ≥ 2 and > `SETTLE_MAX`.
- `SETTLE_MAX`, 40: cycle budget to enter the band after a step.
- `STOP_ON_ERR`, 1: when 1, the first error freezes the stimulus.

Ports:
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: run enable. 0 pauses the phase counter and holds `v_in`.
- `v_in` output `REAL_W`: stimulus applied to `rc_model`.
- `v_out` output `REAL_W`: model output.
- `phase_hi` output 1: 1 while the HIGH step is driven.
- `settled` output 1: `v_out` has entered the band during the current phase.
- `settle_time` output 16: cycles from phase start to band entry, latched per phase.
- `step_count` output 16: completed phase transitions; saturates at 0xFFFF.
- `err_bound` output 1: sticky bound violation.
- `err_settle` output 1: sticky settle timeout.
- `halted` output 1: stimulus frozen by an error.

## Operation

- FSM states:
  - `LOW`: drive `V_LO`. Reset state.
  - `HIGH`: drive `V_HI`.
  - `HALT`: hold the last `v_in`.
- `phase_cnt` counts 0..`HALF_PERIOD`-1 while `en`=1. At `HALF_PERIOD`-1 it wraps to 0, the state toggles between `LOW` and `HIGH`, and `step_count` increments.
- Target is `V_LO` in `LOW` and `V_HI` in `HIGH`.
- In band means |`v_out` − target| ≤ `TOL`. Compute it with `REAL_W`+1-bit subtraction so it cannot overflow.
- Per phase, `settle_cnt` starts at 0 on phase entry and increments each enabled cycle until `settled`.
- On the first in-band sample, set `settled` and latch `settle_time` = `settle_cnt`.
- If `settle_cnt` reaches `SETTLE_MAX` with `settled`=0, set `err_settle`.
- `v_out` ≥ `V_MAX` or ≤ `V_MIN` sets `err_bound`. This is checked every cycle, including while halted or `en`=0.
- When `STOP_ON_ERR`=1 and either error flag sets, enter `HALT`. `halted` goes to 1 and stays until `rst`.
- When `STOP_ON_ERR`=0, errors never change the FSM.
- Formal: immediate assertions require `!err_bound` and `!err_settle`.
- Reset values:
  - FSM in `LOW`; `v_in` = `V_LO`.
  - `phase_hi`, `settled`, `err_*`, `halted` = 0.
  - `settle_time`, `step_count`, `phase_cnt` = 0.
  - `rc_model` held in reset, so `v_out` = 0.

## Timing

- All state is registered. `v_in` changes in the cycle after the phase wrap edge.
- `settled`, `settle_time`, and error flags are registered, and are visible 1 cycle after the `v_out` sample that caused them.
- A phase wrap and a band entry in the same cycle: the wrap wins. The new phase starts with `settled`=0 and `settle_cnt`=0.
- A bound error and a wrap in the same cycle with `STOP_ON_ERR`=1: enter `HALT`. `v_in` keeps its pre-wrap value and `step_count` does not increment.
- `en` deasserted freezes `phase_cnt` and `settle_cnt`. Bound checking continues.
- `rst` asserted mid-phase restores all reset values on the next edge, regardless of state.

## Structure

- Package `rc_chk_pkg`:
  - state enum `{LOW, HIGH, HALT}`;
  - counter width constant (16);
  - fixed-point helper `in_band(a, b, tol)`.
- Sub-module `rc_settle_monitor`: band check, settle counter, `settled`/`settle_time`/`err_settle` latch, bound check.
- The top holds the FSM, phase counter, `rc_model` instance, and the assertions.

## Test plan

- Reset with defaults. Hold `rst` 3 cycles → `v_in`=0.0, `v_out`=0, all flags 0, `step_count`=0. Release → `phase_hi` rises after exactly 64 enabled cycles.
- Defaults, run 4 phases → `step_count`=4, `settled`=1 in every phase, `settle_time` < 40, no errors, `halted`=0.
- `SETTLE_MAX`=2, `TOL`=0.01 → `err_settle`=1 at the 3rd cycle of the first `HIGH` phase, then `halted`=1 and `v_in` frozen at 1.0.
- `V_MAX`=0.5 → `err_bound`=1 one cycle after `v_out` first ≥ 0.5. With `STOP_ON_ERR`=0, stepping continues and `step_count` keeps incrementing.
- `en`=0 for 10 cycles mid-`HIGH` → `phase_cnt` and `settle_cnt` unchanged across the gap, and the phase length extends by 10 cycles.
- `rst` pulsed 1 cycle in `HALT` or mid-`HIGH` → next cycle shows state `LOW`, flags cleared, counters 0.
